// File: rtl/mod_counter_ud.sv
// Up/down modulo-MOD counter with clear, saturating load, wrap pulses and cascade terminal count.
// Define MOD_COUNTER_MATCH_EN to add the cmp_val input and registered match_out output.
module mod_counter_ud #(
    parameter int MOD  = 24,
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            en,
    input  logic            up,
    output logic [BITS-1:0] count_out,
    output logic            carry_out,
    output logic            borrow_out,
    output logic            tc_out
`ifdef MOD_COUNTER_MATCH_EN
    ,
    input  logic [BITS-1:0] cmp_val,
    output logic            match_out
`endif
);

    if (MOD < 2 || MOD > (1 << BITS)) begin : g_bad_mod
        $error("mod_counter_ud: MOD must lie in 2..2**BITS");
    end

    localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);
    localparam logic [BITS-1:0] ONE = BITS'(1);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_COUNT,
        OP_LOAD,
        OP_CLR
    } op_e;

    op_e             op;
    logic [BITS-1:0] count_q, count_d;
    logic            carry_q, carry_d;
    logic            borrow_q, borrow_d;
    logic            at_max, at_zero;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

    always_comb begin
        op = OP_HOLD;
        if (clr)       op = OP_CLR;
        else if (load) op = OP_LOAD;
        else if (en)   op = OP_COUNT;
    end

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (op)
            OP_CLR:  count_d = '0;
            // Out-of-range loads saturate so the count never leaves 0..MOD-1.
            OP_LOAD: count_d = ({1'b0, load_val} > {1'b0, MAX}) ? MAX : load_val;
            OP_COUNT: begin
                if (up) begin
                    count_d = at_max ? '0 : count_q + ONE;
                    carry_d = at_max;
                end else begin
                    count_d  = at_zero ? MAX : count_q - ONE;
                    borrow_d = at_zero;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count_out  = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign tc_out     = en & ((up & at_max) | (~up & at_zero));

`ifdef MOD_COUNTER_MATCH_EN
    logic match_q;

    // Compare against the next count so match_out lines up with count_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) match_q <= 1'b0;
        else     match_q <= (count_d == cmp_val);
    end

    assign match_out = match_q;
`endif

endmodule
